// File: rtl/hazard_stall_controller.sv
// Pipeline interlock for the 5-stage core: load-use bubbles, memory freeze with timeout, branch flush.
// Optional hazard statistics counters (stall_cycles, flush_count) are enabled by defining HAZARD_STATS_EN.
module hazard_stall_controller #(
  parameter int REG_ADDR_W        = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_uses_rs,
  input  logic                  ID_uses_rt,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  input  logic                  EX_memread,
  input  logic                  EX_regwrite,
  input  logic                  EX_branch_taken,
  input  logic                  MEM_req,
  input  logic                  MEM_ready,
  output logic                  pc_en,
  output logic                  IF_ID_en,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_en,
  output logic                  ID_EX_bubble,
  output logic                  EX_MEM_en,
  output logic                  MEM_WB_en,
  output logic                  mem_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_count
`endif
);

  typedef enum logic [1:0] {RUN, LSTALL, MEM_WAIT} state_t;
  typedef enum logic [1:0] {A_RUN, A_FLUSH, A_STALL, A_FREEZE} action_t;

  state_t     state_q, state_d;
  action_t    act;
  logic [2:0] stall_q, stall_d;
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;
  logic       load_use, mem_wait, run_eval;

  assign load_use = EX_memread & EX_regwrite &
                    ((ID_uses_rs & (EX_rd == ID_rs)) | (ID_uses_rt & (EX_rd == ID_rt)));
  assign mem_wait = MEM_req & ~MEM_ready;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    stall_d  = stall_q;
    to_d     = to_q;
    err_d    = err_q;
    act      = A_RUN;
    run_eval = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      LSTALL: begin
        if (mem_wait) begin
          // Remaining bubbles are dropped: the load has advanced and forwarding covers it.
          act     = A_FREEZE;
          to_d    = 8'd1;
          state_d = MEM_WAIT;
        end else if (EX_branch_taken) begin
          act     = A_FLUSH;
          state_d = RUN;
        end else begin
          act     = A_STALL;
          stall_d = stall_q - 3'd1;
          if (stall_q == 3'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (MEM_ready) begin
          run_eval = 1'b1;
        end else if (to_q == 8'(MEM_TIMEOUT - 1)) begin
          // Give up on the access: let the faulting instruction through, flushing a held branch.
          err_d   = 1'b1;
          act     = EX_branch_taken ? A_FLUSH : A_RUN;
          state_d = RUN;
        end else begin
          act  = A_FREEZE;
          to_d = to_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      state_d = RUN;
      if (mem_wait) begin
        act     = A_FREEZE;
        to_d    = 8'd1;
        state_d = MEM_WAIT;
      end else if (EX_branch_taken) begin
        act = A_FLUSH;
      end else if (load_use) begin
        act = A_STALL;
        if (LOAD_STALL_CYCLES > 1) begin
          stall_d = 3'(LOAD_STALL_CYCLES - 1);
          state_d = LSTALL;
        end
      end
    end

    if (!rst_n) act = A_RUN;
  end

  always_comb begin
    pc_en        = 1'b1;
    IF_ID_en     = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_en     = 1'b1;
    ID_EX_bubble = 1'b0;
    EX_MEM_en    = 1'b1;
    MEM_WB_en    = 1'b1;
    case (act)
      A_FLUSH: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
      A_STALL: begin
        pc_en        = 1'b0;
        IF_ID_en     = 1'b0;
        ID_EX_bubble = 1'b1;
      end
      A_FREEZE: begin
        pc_en     = 1'b0;
        IF_ID_en  = 1'b0;
        ID_EX_en  = 1'b0;
        EX_MEM_en = 1'b0;
        MEM_WB_en = 1'b0;
      end
      default: ;
    endcase
  end

  assign mem_err = err_q & rst_n;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= 3'd0;
      to_q    <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_en && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (IF_ID_flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: two instances (1-bubble/timeout 15 and
// 3-bubble/timeout 6) share stimulus and are compared against a cycle-count reference model.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ID_rs, ID_rt, EX_rd;
  logic       ID_uses_rs, ID_uses_rt, EX_memread, EX_regwrite, EX_branch_taken;
  logic       MEM_req, MEM_ready;

  logic [1:0] pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, EX_MEM_en, MEM_WB_en, mem_err;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles [2];
  logic [15:0] flush_count  [2];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_seen [2];

  // Reference model state: bubbles still owed, freeze cycles spent so far, sticky error.
  int m_lsc  [2] = '{1, 3};
  int m_to   [2] = '{15, 6};
  int m_bub  [2] = '{0, 0};
  int m_wait [2] = '{0, 0};
  bit m_err  [2] = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_ADDR_W(3), .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15)) u0 (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs),
    .ID_uses_rt(ID_uses_rt), .EX_rd(EX_rd), .EX_memread(EX_memread), .EX_regwrite(EX_regwrite),
    .EX_branch_taken(EX_branch_taken), .MEM_req(MEM_req), .MEM_ready(MEM_ready),
    .pc_en(pc_en[0]), .IF_ID_en(IF_ID_en[0]), .IF_ID_flush(IF_ID_flush[0]), .ID_EX_en(ID_EX_en[0]),
    .ID_EX_bubble(ID_EX_bubble[0]), .EX_MEM_en(EX_MEM_en[0]), .MEM_WB_en(MEM_WB_en[0]),
    .mem_err(mem_err[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
`endif
  );

  hazard_stall_controller #(.REG_ADDR_W(3), .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(6)) u1 (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs),
    .ID_uses_rt(ID_uses_rt), .EX_rd(EX_rd), .EX_memread(EX_memread), .EX_regwrite(EX_regwrite),
    .EX_branch_taken(EX_branch_taken), .MEM_req(MEM_req), .MEM_ready(MEM_ready),
    .pc_en(pc_en[1]), .IF_ID_en(IF_ID_en[1]), .IF_ID_flush(IF_ID_flush[1]), .ID_EX_en(ID_EX_en[1]),
    .ID_EX_bubble(ID_EX_bubble[1]), .EX_MEM_en(EX_MEM_en[1]), .MEM_WB_en(MEM_WB_en[1]),
    .mem_err(mem_err[1])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
`endif
  );

  task automatic check(input logic [7:0] observed, input logic [7:0] expected, input string tag);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, observed, expected);
    end
  endtask

  task automatic check_int(input int observed, input int expected, input string tag);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Output vector order: {pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, EX_MEM_en, MEM_WB_en, mem_err}
  task automatic model_step(input int k, output logic [7:0] e);
    int  kind;
    bit  lu, mw, decide, e_err;
    logic [6:0] ctl;
    lu = EX_memread && EX_regwrite &&
         ((ID_uses_rs && EX_rd == ID_rs) || (ID_uses_rt && EX_rd == ID_rt));
    mw = MEM_req && !MEM_ready;
    kind  = 0;
    e_err = m_err[k];
    if (!rst_n) begin
      e_err = 1'b0; m_bub[k] = 0; m_wait[k] = 0; m_err[k] = 1'b0;
    end else begin
      decide = 1'b1;
      if (m_wait[k] > 0) begin
        if (MEM_ready) m_wait[k] = 0;
        else begin
          decide = 1'b0;
          if (m_wait[k] + 1 == m_to[k]) begin
            m_err[k] = 1'b1; m_wait[k] = 0; kind = EX_branch_taken ? 1 : 0;
          end else begin
            m_wait[k]++; kind = 3;
          end
        end
      end
      if (decide) begin
        if (mw)                   begin kind = 3; m_wait[k] = 1; m_bub[k] = 0; end
        else if (EX_branch_taken) begin kind = 1; m_bub[k] = 0; end
        else if (m_bub[k] > 0)    begin kind = 2; m_bub[k]--; end
        else if (lu)              begin kind = 2; m_bub[k] = m_lsc[k] - 1; end
      end
    end
    case (kind)
      1:       ctl = 7'b1111111;
      2:       ctl = 7'b0001111;
      3:       ctl = 7'b0000000;
      default: ctl = 7'b1101011;
    endcase
    e = {ctl, e_err};
    if (!rst_n) begin
      m_stall[k] = 0; m_flush[k] = 0;
    end else begin
      if (!ctl[6] && m_stall[k] < 65535) m_stall[k]++;
      if (ctl[4] && m_flush[k] < 65535) m_flush[k]++;
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1 ns later, before the rising edge.
  task automatic step(input bit chk);
    logic [7:0] e, a;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k, e);
      a = {pc_en[k], IF_ID_en[k], IF_ID_flush[k], ID_EX_en[k], ID_EX_bubble[k],
           EX_MEM_en[k], MEM_WB_en[k], mem_err[k]};
      if (!pc_en[k]) stall_seen[k]++;
      if (chk) check(a, e, k == 0 ? "u0_outputs" : "u1_outputs");
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ID_rs = 3'd0; ID_rt = 3'd0; EX_rd = 3'd0;
    ID_uses_rs = 1'b0; ID_uses_rt = 1'b0; EX_memread = 1'b0; EX_regwrite = 1'b0;
    EX_branch_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
  endtask

  task automatic set_load_use(input bit uses_rs, input bit regwrite);
    EX_memread = 1'b1; EX_regwrite = regwrite; EX_rd = 3'd3;
    ID_rs = 3'd3; ID_uses_rs = uses_rs; ID_rt = 3'd5; ID_uses_rt = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    MEM_req = 1'b1;
    @(negedge clk);
    step(1); step(1);
    rst_n = 1'b1;
    idle_inputs();
    step(1);

    // Load-use on rs for one cycle, then the load moves on.
    stall_seen = '{0, 0};
    set_load_use(1'b1, 1'b1);
    step(1);
    idle_inputs();
    repeat (5) step(1);
    check_int(stall_seen[0], 1, "u0_loaduse_stall_len");
    check_int(stall_seen[1], 3, "u1_loaduse_stall_len");

    // No false stall: rs not used, then no register write.
    set_load_use(1'b0, 1'b1); step(1);
    set_load_use(1'b1, 1'b0); step(1);
    // Register 0 still stalls.
    set_load_use(1'b1, 1'b1); EX_rd = 3'd0; ID_rs = 3'd0; step(1);
    idle_inputs(); repeat (3) step(1);

    // Branch together with load-use: branch wins.
    set_load_use(1'b1, 1'b1); EX_branch_taken = 1'b1; step(1);
    idle_inputs(); repeat (3) step(1);

    // Memory wait of 4 cycles, released on the 5th.
    stall_seen = '{0, 0};
    MEM_req = 1'b1; MEM_ready = 1'b0;
    repeat (4) step(1);
    MEM_ready = 1'b1; step(1);
    idle_inputs(); step(1);
    check_int(stall_seen[0], 4, "u0_memwait_len");

    // Branch held during a freeze: flush only on release.
    MEM_req = 1'b1; MEM_ready = 1'b0; EX_branch_taken = 1'b1;
    repeat (3) step(1);
    MEM_ready = 1'b1; step(1);
    idle_inputs(); step(1);

    // Timeout: u0 releases on the 15th frozen cycle, u1 on its 6th; mem_err stays set.
    stall_seen = '{0, 0};
    MEM_req = 1'b1; MEM_ready = 1'b0;
    repeat (15) step(1);
    idle_inputs();
    check_int(stall_seen[0], 14, "u0_timeout_freeze_len");
    repeat (4) step(1);
    set_load_use(1'b1, 1'b1); step(1);
    idle_inputs(); repeat (3) step(1);

    // Reset mid-freeze.
    MEM_req = 1'b1; MEM_ready = 1'b0;
    repeat (3) step(1);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; idle_inputs(); repeat (2) step(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(199) != 0);
      ID_rs           = 3'($urandom);
      ID_rt           = 3'($urandom);
      EX_rd           = ($urandom_range(1) == 1) ? (($urandom_range(1) == 1) ? ID_rs : ID_rt) : 3'($urandom);
      ID_uses_rs      = ($urandom_range(3) != 0);
      ID_uses_rt      = ($urandom_range(1) == 1);
      EX_memread      = ($urandom_range(2) == 0);
      EX_regwrite     = ($urandom_range(3) != 0);
      EX_branch_taken = ($urandom_range(6) == 0);
      MEM_req         = ($urandom_range(3) == 0);
      MEM_ready       = ($urandom_range(2) == 0);
      step(1);
    end
    rst_n = 1'b1; idle_inputs(); step(1);

`ifdef HAZARD_STATS_EN
    check_int(int'(stall_cycles[0]), m_stall[0], "u0_stall_cycles");
    check_int(int'(flush_count[0]),  m_flush[0], "u0_flush_count");
    check_int(int'(stall_cycles[1]), m_stall[1], "u1_stall_cycles");
    check_int(int'(flush_count[1]),  m_flush[1], "u1_flush_count");
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; step(1);
    check_int(int'(stall_cycles[0]), 0, "u0_stall_cycles_after_reset");
    check_int(int'(flush_count[1]),  0, "u1_flush_count_after_reset");
    set_load_use(1'b1, 1'b1);
    repeat (65540) step(0);
    idle_inputs(); step(1);
    check_int(int'(stall_cycles[0]), 65535, "u0_stall_cycles_saturate");
    check_int(int'(stall_cycles[1]), 65535, "u1_stall_cycles_saturate");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline interlock and sequencing controller for the 19-bit 5-stage core. Sits beside the EX-stage forwarding unit.
- Handles the cases forwarding cannot resolve:
  - load-use hazards, by inserting a bubble;
  - multi-cycle data-memory accesses, by freezing the whole pipeline;
  - taken branches, by flushing IF/ID and ID/EX.
- Drives the enable and flush controls of the PC and all pipeline registers.

Parameters:
- REG_ADDR_W, 3, register address width (8-entry register file).
- LOAD_STALL_CYCLES, 1, bubbles per load-use hazard; legal range 1..4.
- MEM_TIMEOUT, 15, maximum freeze cycles before the memory access is abandoned; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- ID_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
- ID_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
- ID_uses_rs  in  1  ID instruction reads rs.
- ID_uses_rt  in  1  ID instruction reads rt.
- EX_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- EX_memread  in  1  EX instruction is a load.
- EX_regwrite  in  1  EX instruction writes the register file.
- EX_branch_taken  in  1  branch resolved taken in EX.
- MEM_req  in  1  MEM instruction is accessing data memory.
- MEM_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- IF_ID_en  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  IF/ID load NOP.
- ID_EX_en  out  1  ID/EX register load enable.
- ID_EX_bubble  out  1  ID/EX load NOP.
- EX_MEM_en  out  1  EX/MEM register load enable.
- MEM_WB_en  out  1  MEM/WB register load enable.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset: all interface inputs and outputs of this block are synchronous to clk; reset is rst_n low sampled at a clock edge.
  - State goes to RUN; stall counter and timeout counter clear to 0; mem_err clears to 0.
  - While rst_n is low, outputs are forced: all *_en = 1, IF_ID_flush = 0, ID_EX_bubble = 0, mem_err = 0.
  - Reset mid-stall or mid-freeze abandons that operation immediately.
- Outputs are Mealy: they are a combinational function of the current state and the current inputs.
- Hazard terms:
  - load_use = EX_memread & EX_regwrite & ((ID_uses_rs & EX_rd==ID_rs) | (ID_uses_rt & EX_rd==ID_rt)).
  - mem_wait = MEM_req & ~MEM_ready.
- Priority, highest first: mem_wait/MEM_WAIT freeze, then branch flush, then load-use stall.
- States: RUN, LSTALL, MEM_WAIT.
- RUN:
  - mem_wait:
    - all *_en = 0; flush and bubble = 0.
    - Load timeout counter with 1; go to MEM_WAIT.
  - else EX_branch_taken:
    - IF_ID_flush = 1, ID_EX_bubble = 1; all enables = 1.
    - Stay in RUN. A branch overrides a simultaneous load_use, because the ID instruction is squashed.
  - else load_use:
    - pc_en = 0, IF_ID_en = 0, ID_EX_bubble = 1; other enables = 1.
    - If LOAD_STALL_CYCLES > 1, load stall counter with LOAD_STALL_CYCLES-1 and go to LSTALL; else stay in RUN.
  - else: all enables = 1, no flush or bubble.
- LSTALL:
  - Outputs are the same as the load-use stall; the counter decrements each cycle.
  - Go to RUN when the counter reaches 0 after the decrement.
  - mem_wait during LSTALL takes priority: go to MEM_WAIT. The remaining bubbles are dropped; the load has advanced and forwarding covers it.
- MEM_WAIT:
  - All *_en = 0; flush and bubble = 0.
  - MEM_ready = 1: this cycle's outputs are the RUN outputs for the current inputs (branch, load-use or none); go to RUN.
  - Otherwise the timeout counter increments.
  - If the counter reaches MEM_TIMEOUT with MEM_ready still 0:
    - set mem_err;
    - release the freeze this cycle: all enables = 1, so the faulting instruction proceeds with undefined data;
    - go to RUN.
  - A branch held in EX during the freeze stays asserted and is flushed on the release cycle.
- mem_err is cleared only by reset.
- Back-to-back load-use hazards are each stalled independently; no cycle is skipped between them.
- Register 0 is not special-cased: EX_rd == 0 still triggers a stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, the following outputs are added:
  - stall_cycles (16-bit): counts cycles with pc_en = 0.
  - flush_count (16-bit): counts cycles with IF_ID_flush = 1.
  - Both counters saturate at 0xFFFF and clear on reset.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use on rs: EX_memread = 1, EX_regwrite = 1, EX_rd = 3, ID_rs = 3, ID_uses_rs = 1. Required: pc_en = 0, IF_ID_en = 0, ID_EX_bubble = 1 for exactly 1 cycle. Repeat with LOAD_STALL_CYCLES = 3: exactly 3 cycles.
- No false stall: same as the first scenario but ID_uses_rs = 0, or EX_regwrite = 0. Required: all enables = 1, no bubble.
- Memory wait: MEM_req = 1, MEM_ready = 0 for 4 cycles, then 1. Required: all enables = 0 for 4 cycles, all = 1 in the 5th cycle, mem_err = 0.
- Timeout: MEM_req = 1, MEM_ready held 0 with MEM_TIMEOUT = 15. Required: freeze for 14 cycles, release on the 15th, mem_err = 1 and sticky until rst_n = 0.
- Simultaneous events:
  - EX_branch_taken = 1 and load_use = 1 in the same cycle. Required: IF_ID_flush = 1, ID_EX_bubble = 1, pc_en = 1.
  - Branch asserted during a MEM_WAIT freeze. Required: the flush appears only on the release cycle.
- Reset mid-freeze: rst_n = 0 during MEM_WAIT. Required: next cycle state is RUN, all enables = 1, counters cleared. With HAZARD_STATS_EN defined: the stat counters read 0 after reset and saturate at 0xFFFF under a long stall.
